// File: rtl/stepper_phase_decoder.sv
// Decodes a 4-bit stepper phase bus into a wrapping step position with skip/illegal detection.
// Latency: input change held stable -> step_valid/position update after 2 + FILTER_CYCLES + 1 cycles.
// Backpressure: none; passive monitor, every accepted pattern is processed in a single cycle.
//
// Ports:
//   Clock, Reset_n      : single rising-edge clock, asynchronous active-low reset
//   StepDrive[3:0]      : phase bus, asynchronous to Clock (2-flop synchronized here)
//   pos_clr, err_clr    : synchronous clear of position / sticky error flags
//   position[POS_W-1:0] : two's-complement step position, wraps modulo 2^POS_W
//   step_valid          : one-cycle pulse per counted step; step_dir gives its direction (1 = forward)
//   released            : last accepted pattern was 4'b0000 (coils off)
//   locked              : decoder holds a valid phase reference (TRACK)
//   err_skip            : sticky, a phase was skipped (delta of 2)
//   err_illegal         : sticky, an illegal pattern was accepted
//   step_period         : cycles between the last two steps (0 unless built with STEP_PERIOD_EN)
//
// Optional feature macro: STEP_PERIOD_EN enables the step period counter.
module stepper_phase_decoder #(
    parameter int POS_W         = 18,
    parameter int FILTER_CYCLES = 3,
    parameter int PER_W         = 16
) (
    input  logic             Clock,
    input  logic             Reset_n,
    input  logic [3:0]       StepDrive,
    input  logic             pos_clr,
    input  logic             err_clr,
    output logic [POS_W-1:0] position,
    output logic             step_valid,
    output logic             step_dir,
    output logic             released,
    output logic             locked,
    output logic             err_skip,
    output logic             err_illegal,
    output logic [PER_W-1:0] step_period
);

    typedef enum logic {
        UNLOCK = 1'b0,
        TRACK  = 1'b1
    } state_t;

    localparam logic [3:0]       FILT_MAX = 4'(FILTER_CYCLES);
    localparam logic [POS_W-1:0] POS_ONE  = POS_W'(1);

    // ------------------------------------------------------------------
    // Input synchronizer and stability filter
    // ------------------------------------------------------------------
    logic [3:0] sync1_q, sync2_q, prev_q;
    logic [3:0] cnt_q, cnt_d;
    logic       acc_vld_q, acc_vld_d;
    logic [3:0] acc_pat_q;
    logic       same;

    always_comb begin
        same      = (sync2_q == prev_q);
        cnt_d     = cnt_q;
        if (!same) begin
            cnt_d = 4'd1;
        end else if (cnt_q < FILT_MAX) begin
            cnt_d = cnt_q + 4'd1;
        end
        // Accept only on the transition into FILT_MAX; a change that restarts the count
        // at 1 is itself the transition when FILTER_CYCLES is 1.
        acc_vld_d = (cnt_d == FILT_MAX) && (!same || (cnt_q != FILT_MAX));
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            sync1_q   <= 4'b0000;
            sync2_q   <= 4'b0000;
            prev_q    <= 4'b0000;
            cnt_q     <= 4'd0;
            acc_vld_q <= 1'b0;
            acc_pat_q <= 4'b0000;
        end else begin
            sync1_q   <= StepDrive;
            sync2_q   <= sync1_q;
            prev_q    <= sync2_q;
            cnt_q     <= cnt_d;
            acc_vld_q <= acc_vld_d;
            acc_pat_q <= sync2_q;
        end
    end

    // ------------------------------------------------------------------
    // Phase decode of the accepted pattern
    // ------------------------------------------------------------------
    logic       pat_legal, pat_rel;
    logic [1:0] pat_idx;

    always_comb begin
        pat_legal = 1'b1;
        pat_rel   = 1'b0;
        pat_idx   = 2'd0;
        case (acc_pat_q)
            4'b1010: pat_idx = 2'd0;
            4'b1001: pat_idx = 2'd1;
            4'b0101: pat_idx = 2'd2;
            4'b0110: pat_idx = 2'd3;
            4'b0000: begin
                pat_legal = 1'b0;
                pat_rel   = 1'b1;
            end
            default: pat_legal = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Lock/track FSM and position counter
    // ------------------------------------------------------------------
    state_t           state_q, state_d;
    logic [1:0]       idx_q, idx_d, delta;
    logic [POS_W-1:0] pos_q, pos_d;
    logic             sv_q, sv_d;
    logic             dir_q, dir_d;
    logic             rel_q, rel_d;
    logic             eskip_q, eskip_d;
    logic             eill_q, eill_d;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        pos_d   = pos_q;
        sv_d    = 1'b0;
        dir_d   = dir_q;
        rel_d   = rel_q;
        // Clear first so an error detected in the same cycle still leaves the flag set.
        eskip_d = err_clr ? 1'b0 : eskip_q;
        eill_d  = err_clr ? 1'b0 : eill_q;
        // 2-bit subtraction gives (new - stored) mod 4 directly.
        delta   = pat_idx - idx_q;

        if (acc_vld_q) begin
            if (pat_legal) begin
                rel_d = 1'b0;
                idx_d = pat_idx;
                if (state_q == UNLOCK) begin
                    state_d = TRACK;
                end else begin
                    case (delta)
                        2'd1: begin
                            pos_d = pos_q + POS_ONE;
                            dir_d = 1'b1;
                            sv_d  = 1'b1;
                        end
                        2'd3: begin
                            pos_d = pos_q - POS_ONE;
                            dir_d = 1'b0;
                            sv_d  = 1'b1;
                        end
                        2'd2:    eskip_d = 1'b1;
                        // Same phase re-accepted after a rejected glitch: nothing moved.
                        default: ;
                    endcase
                end
            end else if (pat_rel) begin
                rel_d   = 1'b1;
                state_d = UNLOCK;
            end else begin
                eill_d  = 1'b1;
                state_d = UNLOCK;
            end
        end

        // Clear overrides the count but the step pulse and direction still report.
        if (pos_clr) begin
            pos_d = '0;
        end
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= UNLOCK;
            idx_q   <= 2'd0;
            pos_q   <= '0;
            sv_q    <= 1'b0;
            dir_q   <= 1'b1;
            rel_q   <= 1'b1;
            eskip_q <= 1'b0;
            eill_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            pos_q   <= pos_d;
            sv_q    <= sv_d;
            dir_q   <= dir_d;
            rel_q   <= rel_d;
            eskip_q <= eskip_d;
            eill_q  <= eill_d;
        end
    end

    assign position    = pos_q;
    assign step_valid  = sv_q;
    assign step_dir    = dir_q;
    assign released    = rel_q;
    assign locked      = (state_q == TRACK);
    assign err_skip    = eskip_q;
    assign err_illegal = eill_q;

    // ------------------------------------------------------------------
    // Optional step period measurement
    // ------------------------------------------------------------------
`ifdef STEP_PERIOD_EN
    localparam logic [PER_W-1:0] PER_ONE = PER_W'(1);

    logic [PER_W-1:0] per_cnt_q, per_cnt_d;
    logic [PER_W-1:0] per_q, per_d;

    always_comb begin
        per_cnt_d = per_cnt_q;
        per_d     = per_q;
        if (state_d == UNLOCK) begin
            // Losing lock invalidates the timing reference; the first step after
            // re-lock then reports the saturated value.
            per_cnt_d = '1;
        end else if (sv_d) begin
            per_d     = per_cnt_q;
            per_cnt_d = PER_ONE;
        end else if (per_cnt_q != '1) begin
            per_cnt_d = per_cnt_q + PER_ONE;
        end
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            per_cnt_q <= '1;
            per_q     <= '0;
        end else begin
            per_cnt_q <= per_cnt_d;
            per_q     <= per_d;
        end
    end

    assign step_period = per_q;
`else
    assign step_period = '0;
`endif

endmodule
